// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu - memory-stage load/store unit
//
// Takes the execute-stage write-back triple (wd/wreg/wdata) together with an
// optional memory request. Loads and stores are carried out one byte per
// cycle over an 8-bit little-endian memory port. The final write-back triple
// is returned with a one-cycle valid_o pulse. Requests with no memory
// operation, and requests with an illegal size code, pass straight through
// in one cycle.
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   valid_i        request present (sampled only while IDLE)
//   wd_i, wreg_i   destination register and its write enable
//   wdata_i        execute result, returned unchanged for non-memory ops
//   mem_re_i       load request
//   mem_we_i       store request (has priority over mem_re_i)
//   func3_i        size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_addr_i     byte address of the access
//   mem_wdata_i    store data
//   mem_din_i      read byte, valid the cycle after its address
//   mem_a_o        byte address to memory (holds when idle)
//   mem_dout_o     write byte
//   mem_wr_o       write strobe
//   valid_o        one-cycle pulse qualifying wd_o/wreg_o/wdata_o
//   wd_o, wreg_o   destination register and its write enable
//   wdata_o        write-back data
//   stallreq_o     combinational stall request to upstream stages
// ---------------------------------------------------------------------------
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  func3_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [2:0]  k, k_d;          // byte index of the access in progress
    logic [2:0]  k_inc;

    // Request captured in IDLE
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [2:0]  f3_q;
    logic [2:0]  len_q;

    logic [31:0] rbuf;            // load assembly buffer, lane k = byte k
    logic [31:0] assembled;
    logic [31:0] load_result;
    logic [4:0]  lane_sh;

    logic        load_ok, store_ok;
    logic        accept, do_store, do_load, illegal;
    logic        last_write, last_read;

    function automatic logic [2:0] len_of(input logic [1:0] sz);
        case (sz)
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    // Request decode. A store with an illegal size is still a store (so it
    // beats a simultaneous load) and becomes a no-write pass-through.
    always_comb begin
        load_ok    = func3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        store_ok   = func3_i inside {3'b000, 3'b001, 3'b010};
        accept     = (state == IDLE) && valid_i;
        do_store   = accept && mem_we_i && store_ok;
        do_load    = accept && !mem_we_i && mem_re_i && load_ok;
        illegal    = accept && (mem_we_i ? !store_ok : (mem_re_i && !load_ok));
        k_inc      = k + 3'd1;
        last_write = (state == WRITE) && (k_inc == len_q);
        // A load stays in READ one cycle longer than it issues addresses:
        // the last byte arrives the cycle after the last address.
        last_read  = (state == READ) && (k == len_q);
    end

    // While reading, the byte on mem_din_i belongs to lane k-1. Merge it
    // combinationally so the final byte is included in the completing cycle.
    always_comb begin
        lane_sh     = {k[1:0] - 2'd1, 3'b000};
        assembled   = (rbuf & ~(32'h0000_00FF << lane_sh))
                    | ({24'd0, mem_din_i} << lane_sh);
        case (f3_q)
            3'b000:  load_result = {{24{assembled[7]}},  assembled[7:0]};
            3'b001:  load_result = {{16{assembled[15]}}, assembled[15:0]};
            3'b100:  load_result = {24'd0, assembled[7:0]};
            3'b101:  load_result = {16'd0, assembled[15:0]};
            default: load_result = assembled;
        endcase
    end

    assign stallreq_o = (state != IDLE) || (valid_i && (mem_re_i || mem_we_i));

    // Next-state logic
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state;
        k_d     = k;
        case (state)
            IDLE: begin
                k_d = 3'd0;
                if (do_store)     state_d = WRITE;
                else if (do_load) state_d = READ;
            end
            WRITE: begin
                k_d = k_inc;
                if (last_write) state_d = IDLE;
            end
            READ: begin
                k_d = k_inc;
                if (last_read) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k     <= 3'd0;
        end else begin
            state <= state_d;
            k     <= k_d;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q       <= 5'd0;
            wreg_q     <= 1'b0;
            wdata_q    <= 32'd0;
            addr_q     <= 32'd0;
            sdata_q    <= 32'd0;
            f3_q       <= 3'd0;
            len_q      <= 3'd1;
            rbuf       <= 32'd0;
            mem_a_o    <= 32'd0;
            mem_dout_o <= 8'd0;
            mem_wr_o   <= 1'b0;
            valid_o    <= 1'b0;
            wd_o       <= 5'd0;
            wreg_o     <= 1'b0;
            wdata_o    <= 32'd0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wd_q    <= wd_i;
                        wreg_q  <= wreg_i;
                        wdata_q <= wdata_i;
                        addr_q  <= mem_addr_i;
                        sdata_q <= mem_wdata_i;
                        f3_q    <= func3_i;
                        len_q   <= len_of(func3_i[1:0]);
                        rbuf    <= 32'd0;
                        if (do_store) begin
                            mem_a_o    <= mem_addr_i;
                            mem_dout_o <= mem_wdata_i[7:0];
                            mem_wr_o   <= 1'b1;
                        end else if (do_load) begin
                            mem_a_o  <= mem_addr_i;
                            mem_wr_o <= 1'b0;
                        end else begin
                            valid_o <= 1'b1;
                            wd_o    <= wd_i;
                            wreg_o  <= wreg_i && !illegal;
                            wdata_o <= illegal ? 32'd0 : wdata_i;
                        end
                    end
                end
                WRITE: begin
                    if (last_write) begin
                        mem_wr_o <= 1'b0;
                        valid_o  <= 1'b1;
                        wd_o     <= wd_q;
                        wreg_o   <= wreg_q;
                        wdata_o  <= wdata_q;
                    end else begin
                        mem_a_o    <= addr_q + {29'd0, k_inc};
                        mem_dout_o <= sdata_q[{k_inc[1:0], 3'b000} +: 8];
                    end
                end
                READ: begin
                    if (k != 3'd0) rbuf <= assembled;
                    if (k_inc < len_q) mem_a_o <= addr_q + {29'd0, k_inc};
                    if (last_read) begin
                        valid_o <= 1'b1;
                        wd_o    <= wd_q;
                        wreg_o  <= wreg_q;
                        wdata_o <= load_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
